// File: rtl/mc_pkg.sv
// Shared types for the multi-cycle core sequencer: FSM states and trap causes.
package mc_pkg;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } trap_cause_e;
endpackage

// File: rtl/mc_bus_port.sv
// One valid/ready request followed by a response, with a watchdog spanning both phases.
// A timeout drops the request on its own so the owner only has to react to the pulse.
module mc_bus_port #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic req_rdy,
  input  logic rsp_vld,
  output logic req_vld,
  output logic done,
  output logic timeout
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic          req_vld_reg;
  logic          wait_reg;
  logic [CW-1:0] cnt_reg;
  logic          busy;

  assign busy    = req_vld_reg | wait_reg;
  assign done    = wait_reg & rsp_vld;
  // A response in the last allowed cycle still counts as completion.
  assign timeout = (TIMEOUT != 0) && busy && !done && (cnt_reg == LIMIT);
  assign req_vld = req_vld_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_vld_reg <= 1'b0;
      wait_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else if (start) begin
      req_vld_reg <= 1'b1;
      wait_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else if (timeout) begin
      req_vld_reg <= 1'b0;
      wait_reg    <= 1'b0;
    end else begin
      if (req_vld_reg && req_rdy) begin
        req_vld_reg <= 1'b0;
        wait_reg    <= 1'b1;
      end
      if (done) wait_reg <= 1'b0;
      if (busy) cnt_reg <= cnt_reg + CW'(1);
    end
  end
endmodule

// File: rtl/mc_core_ctrl.sv
// Multi-cycle RV32 sequencer: PC/IR, state machine, imem/dmem handshakes, retire count, sticky trap.
// The next PC is resolved in EXEC so retire is a registered pulse that lines up with WB.
module mc_core_ctrl import mc_pkg::*; #(
  parameter int          AW       = 32,
  parameter int          DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_vld,
  output logic [AW-1:0]    imem_req_adr,
  input  logic             imem_req_rdy,
  input  logic             imem_rsp_vld,
  input  logic [DW-1:0]    imem_rsp_dat,
  output logic             dmem_req_vld,
  output logic             dmem_req_we,
  output logic [AW-1:0]    dmem_req_adr,
  output logic [DW-1:0]    dmem_req_dat,
  input  logic             dmem_req_rdy,
  input  logic             dmem_rsp_vld,
  input  logic [DW-1:0]    dmem_rsp_dat,
  input  logic             is_mem_load,
  input  logic             is_mem_store,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic             is_branch,
  input  logic             is_illegal,
  input  logic             branch_taken,
  input  logic [DW-1:0]    alu_res,
  input  logic [DW-1:0]    rs2_data,
  output logic [DW-1:0]    instr,
  output logic [AW-1:0]    pc,
  output logic [DW-1:0]    load_data,
  output logic             rf_wr_en,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);
  state_e      state_reg;
  trap_cause_e trap_cause_reg;
  logic [AW-1:0]    pc_reg, next_pc_reg, dmem_adr_reg;
  logic [DW-1:0]    instr_reg, load_data_reg, dmem_dat_reg;
  logic [CNT_W-1:0] instret_reg;
  logic             dmem_we_reg, retire_reg, rf_wr_en_reg, trap_reg;

  logic          imem_start, imem_done, imem_tmo;
  logic          dmem_start, dmem_done, dmem_tmo;
  logic          mem_op;
  logic [AW-1:0] exec_next;

  assign mem_op = is_mem_load | is_mem_store;

  always_comb begin
    exec_next = pc_reg + AW'(INSTR_BYTES);
    if (is_jal || (is_branch && branch_taken)) exec_next = alu_res[AW-1:0];
    else if (is_jalr)                          exec_next = {alu_res[AW-1:1], 1'b0};
  end

  // Second term only fires for the first fetch after reset, when the port is still idle.
  assign imem_start = ((state_reg == S_WB) && retire_reg) ||
                      ((state_reg == S_FETCH_REQ) && !imem_req_vld);
  assign dmem_start = (state_reg == S_EXEC) && mem_op && (alu_res[1:0] == 2'b00);

  mc_bus_port #(.TIMEOUT(TIMEOUT)) u_imem_port (
    .clk     (clk),
    .rst     (rst),
    .start   (imem_start),
    .req_rdy (imem_req_rdy),
    .rsp_vld (imem_rsp_vld),
    .req_vld (imem_req_vld),
    .done    (imem_done),
    .timeout (imem_tmo)
  );

  mc_bus_port #(.TIMEOUT(TIMEOUT)) u_dmem_port (
    .clk     (clk),
    .rst     (rst),
    .start   (dmem_start),
    .req_rdy (dmem_req_rdy),
    .rsp_vld (dmem_rsp_vld),
    .req_vld (dmem_req_vld),
    .done    (dmem_done),
    .timeout (dmem_tmo)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= S_FETCH_REQ;
      pc_reg         <= RESET_PC;
      next_pc_reg    <= '0;
      instr_reg      <= '0;
      load_data_reg  <= '0;
      instret_reg    <= '0;
      dmem_adr_reg   <= '0;
      dmem_dat_reg   <= '0;
      dmem_we_reg    <= 1'b0;
      retire_reg     <= 1'b0;
      rf_wr_en_reg   <= 1'b0;
      trap_reg       <= 1'b0;
      trap_cause_reg <= CAUSE_NONE;
    end else begin
      retire_reg   <= 1'b0;
      rf_wr_en_reg <= 1'b0;
      unique case (state_reg)
        S_FETCH_REQ: begin
          if (imem_tmo) begin
            state_reg <= S_TRAP; trap_reg <= 1'b1; trap_cause_reg <= CAUSE_TIMEOUT;
          end else if (imem_req_vld && imem_req_rdy) begin
            state_reg <= S_FETCH_WAIT;
          end
        end
        S_FETCH_WAIT: begin
          if (imem_done) begin
            instr_reg <= imem_rsp_dat;
            state_reg <= S_DECODE;
          end else if (imem_tmo) begin
            state_reg <= S_TRAP; trap_reg <= 1'b1; trap_cause_reg <= CAUSE_TIMEOUT;
          end
        end
        S_DECODE: begin
          if (is_illegal) begin
            state_reg <= S_TRAP; trap_reg <= 1'b1; trap_cause_reg <= CAUSE_ILLEGAL;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          next_pc_reg <= exec_next;
          if (mem_op) begin
            if (alu_res[1:0] != 2'b00) begin
              state_reg <= S_TRAP; trap_reg <= 1'b1; trap_cause_reg <= CAUSE_MISALIGN;
            end else begin
              dmem_adr_reg <= alu_res[AW-1:0];
              dmem_dat_reg <= rs2_data;
              dmem_we_reg  <= is_mem_store;
              state_reg    <= S_MEM_REQ;
            end
          end else begin
            state_reg    <= S_WB;
            retire_reg   <= (exec_next[1:0] == 2'b00);
            rf_wr_en_reg <= !is_branch;
          end
        end
        S_MEM_REQ: begin
          if (dmem_tmo) begin
            state_reg <= S_TRAP; trap_reg <= 1'b1; trap_cause_reg <= CAUSE_TIMEOUT;
          end else if (dmem_req_vld && dmem_req_rdy) begin
            state_reg <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_done) begin
            if (!dmem_we_reg) load_data_reg <= dmem_rsp_dat;
            state_reg    <= S_WB;
            retire_reg   <= (next_pc_reg[1:0] == 2'b00);
            rf_wr_en_reg <= !dmem_we_reg;
          end else if (dmem_tmo) begin
            state_reg <= S_TRAP; trap_reg <= 1'b1; trap_cause_reg <= CAUSE_TIMEOUT;
          end
        end
        S_WB: begin
          // retire_reg already encodes "next PC is aligned"
          if (retire_reg) begin
            pc_reg      <= next_pc_reg;
            instret_reg <= instret_reg + CNT_W'(1);
            state_reg   <= S_FETCH_REQ;
          end else begin
            state_reg <= S_TRAP; trap_reg <= 1'b1; trap_cause_reg <= CAUSE_MISALIGN;
          end
        end
        S_TRAP: state_reg <= S_TRAP;
        default: state_reg <= S_TRAP;
      endcase
    end
  end

  assign imem_req_adr = pc_reg;
  assign dmem_req_we  = dmem_we_reg;
  assign dmem_req_adr = dmem_adr_reg;
  assign dmem_req_dat = dmem_dat_reg;
  assign instr        = instr_reg;
  assign pc           = pc_reg;
  assign load_data    = load_data_reg;
  assign rf_wr_en     = rf_wr_en_reg;
  assign retire       = retire_reg;
  assign instret      = instret_reg;
  assign trap         = trap_reg;
  assign trap_cause   = trap_cause_reg;
endmodule
